// File: rtl/proc_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
// Shared types and constants for the 9-bit simple processor control unit.
//   opcode_t : instruction opcodes carried in IR[8:6]
//   state_t  : instruction-sequencing step (T0..T3)
//   IR_*     : bit positions of the opcode / Rx / Ry fields inside IR
// ---------------------------------------------------------------------------
package proc_pkg;

  localparam int BUS_W = 9;
  localparam int NREGS = 8;

  // IR field positions: IR[8:6] opcode, IR[5:3] Rx, IR[2:0] Ry
  localparam int IR_OP_HI = 8;
  localparam int IR_OP_LO = 6;
  localparam int IR_RX_HI = 5;
  localparam int IR_RX_LO = 3;
  localparam int IR_RY_HI = 2;
  localparam int IR_RY_LO = 0;

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011
  } opcode_t;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

endpackage

// File: rtl/proc_control_unit_if.sv
// ---------------------------------------------------------------------------
// proc_control_unit_if
// Signals between the control unit and the rest of the processor.
//   Din, Run          : instruction/immediate word and start request
//   Rout, Gout, DINout: bus-driver selects (at most one active)
//   Rin, Ain, Gin     : register load enables
//   AddSub            : ALU op (0 add, 1 subtract)
//   IRin, Done, IR    : IR load strobe, completion pulse, IR contents
// Modports: master = control unit, slave = datapath / environment.
// ---------------------------------------------------------------------------
interface proc_control_unit_if;
  import proc_pkg::*;

  logic [BUS_W-1:0] Din;
  logic             Run;
  logic [NREGS-1:0] Rout;
  logic             Gout;
  logic             DINout;
  logic [NREGS-1:0] Rin;
  logic             Ain;
  logic             Gin;
  logic             AddSub;
  logic             IRin;
  logic             Done;
  logic [BUS_W-1:0] IR;

  modport master (
    input  Din, Run,
    output Rout, Gout, DINout, Rin, Ain, Gin, AddSub, IRin, Done, IR
  );

  modport slave (
    output Din, Run,
    input  Rout, Gout, DINout, Rin, Ain, Gin, AddSub, IRin, Done, IR
  );

endinterface

// File: rtl/proc_control_unit_dec3to8.sv
// ---------------------------------------------------------------------------
// dec3to8
// 3-to-8 one-hot decoder with enable.
//   sel    : register index
//   en     : when 0 every output is 0
//   onehot : bit sel set when enabled
// ---------------------------------------------------------------------------
module dec3to8 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] onehot
);

  for (genvar gi = 0; gi < 8; gi++) begin : g_dec
    assign onehot[gi] = en && (sel == 3'(gi));
  end

endmodule

// File: rtl/proc_control_unit.sv
// ---------------------------------------------------------------------------
// proc_control_unit
// Instruction-sequencing FSM for the 9-bit simple processor. Latches an
// instruction from Din in T0 when Run is high, then steps through T1..T3
// producing bus-driver selects and load/ALU strobes.
//   Clock  : system clock, rising edge
//   Resetn : asynchronous active-low reset; forces every output to 0
//   bus    : proc_control_unit_if.master (Din/Run in, control strobes out)
// Outputs are combinational from state and IR (Run also feeds IRin in T0).
// ---------------------------------------------------------------------------
module proc_control_unit
  import proc_pkg::*;
(
  input  logic                   Clock,
  input  logic                   Resetn,
  proc_control_unit_if.master    bus
);

  state_t           state;
  logic [BUS_W-1:0] ir;

  logic [2:0] ir_op;
  logic [2:0] ir_rx;
  logic [2:0] ir_ry;

  assign ir_op = ir[IR_OP_HI:IR_OP_LO];
  assign ir_rx = ir[IR_RX_HI:IR_RX_LO];
  assign ir_ry = ir[IR_RY_HI:IR_RY_LO];

  // State and IR register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= T0;
      ir    <= '0;
    end else begin
      unique case (state)
        T0: begin
          if (bus.Run) begin
            ir    <= bus.Din;
            state <= T1;
          end
        end
        T1: begin
          if (ir_op == OP_ADD || ir_op == OP_SUB) state <= T2;
          else                                    state <= T0;
        end
        T2:      state <= T3;
        default: state <= T0;
      endcase
    end
  end

  // Per-step control decisions, before register decoding and reset gating
  logic rout_rx, rout_ry, rin_rx;
  logic gout_c, dinout_c, ain_c, gin_c, addsub_c, irin_c, done_c;

  always_comb begin
    rout_rx  = 1'b0;
    rout_ry  = 1'b0;
    rin_rx   = 1'b0;
    gout_c   = 1'b0;
    dinout_c = 1'b0;
    ain_c    = 1'b0;
    gin_c    = 1'b0;
    addsub_c = 1'b0;
    irin_c   = 1'b0;
    done_c   = 1'b0;
    unique case (state)
      T0: irin_c = bus.Run;
      T1: begin
        case (ir_op)
          OP_MV: begin
            rout_ry = 1'b1;
            rin_rx  = 1'b1;
            done_c  = 1'b1;
          end
          OP_MVI: begin
            dinout_c = 1'b1;
            rin_rx   = 1'b1;
            done_c   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout_rx = 1'b1;
            ain_c   = 1'b1;
          end
          // reserved opcodes complete as a NOP
          default: done_c = 1'b1;
        endcase
      end
      T2: begin
        rout_ry  = 1'b1;
        gin_c    = 1'b1;
        addsub_c = ir[IR_OP_LO];
      end
      default: begin
        gout_c = 1'b1;
        rin_rx = 1'b1;
        done_c = 1'b1;
      end
    endcase
  end

  // Rx is used for either Rout or Rin, never both in the same step, so one
  // decoder serves both; Ry only ever selects a bus driver.
  logic [NREGS-1:0] rx_onehot;
  logic [NREGS-1:0] ry_onehot;

  dec3to8 u_dec_rx (
    .sel    (ir_rx),
    .en     (Resetn && (rout_rx || rin_rx)),
    .onehot (rx_onehot)
  );

  dec3to8 u_dec_ry (
    .sel    (ir_ry),
    .en     (Resetn && rout_ry),
    .onehot (ry_onehot)
  );

  // Resetn gates everything so enables drop the instant reset asserts,
  // without waiting for the registers to settle.
  assign bus.Rout   = (rout_rx ? rx_onehot : '0) | ry_onehot;
  assign bus.Rin    = rin_rx ? rx_onehot : '0;
  assign bus.Gout   = Resetn && gout_c;
  assign bus.DINout = Resetn && dinout_c;
  assign bus.Ain    = Resetn && ain_c;
  assign bus.Gin    = Resetn && gin_c;
  assign bus.AddSub = Resetn && addsub_c;
  assign bus.IRin   = Resetn && irin_c;
  assign bus.Done   = Resetn && done_c;
  assign bus.IR     = Resetn ? ir : '0;

  // Only one source may drive the shared bus in any cycle
  a_bus_onehot: assert property (@(posedge Clock) disable iff (!Resetn)
    $onehot0({bus.Rout, bus.Gout, bus.DINout}));

endmodule

// File: tb/tb_proc_control_unit.sv
// ---------------------------------------------------------------------------
// tb_proc_control_unit
// Directed stimulus with a scoreboard: each driven cycle pushes its
// hand-computed expected outputs; a monitor on the falling edge pops and
// compares them against the DUT, and checks bus-driver exclusivity.
// ---------------------------------------------------------------------------
module tb_proc_control_unit;
  import proc_pkg::*;

  typedef struct packed {
    logic [7:0] rout;
    logic       gout;
    logic       dinout;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       irin;
    logic       done;
    logic [8:0] ir;
  } outs_t;

  logic Clock;
  logic Resetn;

  proc_control_unit_if bus ();

  proc_control_unit dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  outs_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  string name_q[$];

  function automatic outs_t mk(input logic [7:0] rout, input logic gout,
                               input logic dinout, input logic [7:0] rin,
                               input logic ain, input logic gin,
                               input logic addsub, input logic irin,
                               input logic done, input logic [8:0] ir);
    outs_t o;
    o.rout = rout; o.gout = gout; o.dinout = dinout; o.rin = rin;
    o.ain = ain; o.gin = gin; o.addsub = addsub; o.irin = irin;
    o.done = done; o.ir = ir;
    return o;
  endfunction

  // Drive one cycle's inputs just after the rising edge and record the
  // outputs that cycle must show.
  task automatic step(input string nm, input logic rn, input logic [8:0] d,
                      input logic r, input outs_t e);
    @(posedge Clock);
    #1;
    Resetn  = rn;
    bus.Din = d;
    bus.Run = r;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares on the falling edge, away from the active edge
  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      outs_t e, a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {bus.Rout, bus.Gout, bus.DINout, bus.Rin, bus.Ain, bus.Gin,
            bus.AddSub, bus.IRin, bus.Done, bus.IR};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got rout=%h gout=%b dinout=%b rin=%h ain=%b gin=%b addsub=%b irin=%b done=%b ir=%h, required rout=%h gout=%b dinout=%b rin=%h ain=%b gin=%b addsub=%b irin=%b done=%b ir=%h",
                 nm, a.rout, a.gout, a.dinout, a.rin, a.ain, a.gin, a.addsub, a.irin, a.done, a.ir,
                 e.rout, e.gout, e.dinout, e.rin, e.ain, e.gin, e.addsub, e.irin, e.done, e.ir);
      end else begin
        $display("ok   %s: rout=%h rin=%h done=%b ir=%h", nm, a.rout, a.rin, a.done, a.ir);
      end
      vectors++;
      if (!$onehot0({bus.Rout, bus.Gout, bus.DINout})) begin
        miscompares++;
        $display("FAIL %s onehot: got drivers=%b, required at most one set",
                 nm, {bus.Rout, bus.Gout, bus.DINout});
      end
    end
  end

  outs_t z;

  initial begin
    z       = '0;
    Resetn  = 1'b0;
    bus.Din = '0;
    bus.Run = 1'b0;

    // Reset held: Run high must not leak through IRin
    step("reset_hold",   1'b0, 9'h000, 1'b1, z);
    step("reset_run",    1'b0, 9'h068, 1'b1, z);
    step("after_reset",  1'b1, 9'h000, 1'b0, z);

    // mvi R5,#0x1A5
    step("mvi_t0", 1'b1, 9'h068, 1'b1, mk(8'h00,0,0,8'h00,0,0,0,1,0,9'h000));
    step("mvi_t1", 1'b1, 9'h1A5, 1'b0, mk(8'h00,0,1,8'h20,0,0,0,0,1,9'h068));

    // mv R0,R7
    step("mv_t0",  1'b1, 9'h007, 1'b1, mk(8'h00,0,0,8'h00,0,0,0,1,0,9'h068));
    step("mv_t1",  1'b1, 9'h000, 1'b0, mk(8'h80,0,0,8'h01,0,0,0,0,1,9'h007));

    // sub R1,R2
    step("sub_t0", 1'b1, 9'h0CA, 1'b1, mk(8'h00,0,0,8'h00,0,0,0,1,0,9'h007));
    step("sub_t1", 1'b1, 9'h000, 1'b0, mk(8'h02,0,0,8'h00,1,0,0,0,0,9'h0CA));
    step("sub_t2", 1'b1, 9'h000, 1'b0, mk(8'h04,0,0,8'h00,0,1,1,0,0,9'h0CA));
    step("sub_t3", 1'b1, 9'h000, 1'b0, mk(8'h00,1,0,8'h02,0,0,0,0,1,9'h0CA));

    // add R2,R2 with Run pulsed during T1..T3 (ignored, IR unchanged)
    step("add_t0", 1'b1, 9'h092, 1'b1, mk(8'h00,0,0,8'h00,0,0,0,1,0,9'h0CA));
    step("add_t1", 1'b1, 9'h1FF, 1'b1, mk(8'h04,0,0,8'h00,1,0,0,0,0,9'h092));
    step("add_t2", 1'b1, 9'h1FF, 1'b1, mk(8'h04,0,0,8'h00,0,1,0,0,0,9'h092));
    step("add_t3", 1'b1, 9'h1FF, 1'b1, mk(8'h00,1,0,8'h04,0,0,0,0,1,9'h092));

    // reserved opcode accepted in the cycle right after Done
    step("nop_t0", 1'b1, 9'h1C0, 1'b1, mk(8'h00,0,0,8'h00,0,0,0,1,0,9'h092));
    step("nop_t1", 1'b1, 9'h000, 1'b0, mk(8'h00,0,0,8'h00,0,0,0,0,1,9'h1C0));

    // Run held high: mv R3,R3 then add R4,R1 back to back
    step("mv33_t0", 1'b1, 9'h01B, 1'b1, mk(8'h00,0,0,8'h00,0,0,0,1,0,9'h1C0));
    step("mv33_t1", 1'b1, 9'h0A1, 1'b1, mk(8'h08,0,0,8'h08,0,0,0,0,1,9'h01B));
    step("add41_t0",1'b1, 9'h0A1, 1'b1, mk(8'h00,0,0,8'h00,0,0,0,1,0,9'h01B));
    step("add41_t1",1'b1, 9'h000, 1'b0, mk(8'h10,0,0,8'h00,1,0,0,0,0,9'h0A1));

    // Reset asserted just after entering T2: everything drops at once
    step("rst_mid_t2", 1'b0, 9'h000, 1'b0, z);
    step("rst_run",    1'b0, 9'h0A1, 1'b1, z);
    step("rst_release",1'b1, 9'h000, 1'b0, z);
    step("idle_t0",    1'b1, 9'h000, 1'b0, z);

    // Drain the scoreboard with a bounded wait
    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 20) begin
        @(posedge Clock);
        budget++;
      end
      if (exp_q.size() > 0) begin
        miscompares++;
        $display("FAIL drain: got %0d pending, required 0", exp_q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
